// File: rtl/codec_config_sequencer.sv
// WM8731 configuration sequencer: power-up wait, 12-word register table over a shared
// I2C write master with NACK retries, then runtime headphone-volume writes via req/ack.
module codec_config_sequencer #(
  parameter logic [6:0] DEV_ADDR     = 7'h1A,
  parameter int         PWRUP_CYCLES = 50000,
  parameter int         GAP_CYCLES   = 1000,
  parameter int         MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        i2c_req,
  output logic [6:0]  i2c_dev_addr,
  output logic [15:0] i2c_data,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  input  logic        vol_req,
  input  logic [6:0]  vol_val,
  output logic        vol_ack,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [3:0]  cfg_index
);

  localparam int CNT_MAX = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX    = RTY_W'(MAX_RETRY);
  localparam logic [3:0]       LAST_IDX   = 4'd11;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_PWRUP     = 4'd1;
  localparam logic [3:0] S_ISSUE     = 4'd2;
  localparam logic [3:0] S_WAIT      = 4'd3;
  localparam logic [3:0] S_GAP       = 4'd4;
  localparam logic [3:0] S_DONE      = 4'd5;
  localparam logic [3:0] S_ERROR     = 4'd6;
  localparam logic [3:0] S_VOL_ISSUE = 4'd7;
  localparam logic [3:0] S_VOL_WAIT  = 4'd8;

  function automatic logic [15:0] table_word(input logic [3:0] idx);
    logic [6:0] ra;
    logic [8:0] rd;
    case (idx)
      4'd0:    begin ra = 7'd15; rd = 9'h000; end
      4'd1:    begin ra = 7'd6;  rd = 9'h010; end
      4'd2:    begin ra = 7'd0;  rd = 9'h017; end
      4'd3:    begin ra = 7'd1;  rd = 9'h017; end
      4'd4:    begin ra = 7'd2;  rd = 9'h079; end
      4'd5:    begin ra = 7'd3;  rd = 9'h079; end
      4'd6:    begin ra = 7'd4;  rd = 9'h012; end
      4'd7:    begin ra = 7'd5;  rd = 9'h000; end
      4'd8:    begin ra = 7'd7;  rd = 9'h042; end
      4'd9:    begin ra = 7'd8;  rd = 9'h000; end
      4'd10:   begin ra = 7'd9;  rd = 9'h001; end
      default: begin ra = 7'd6;  rd = 9'h000; end
    endcase
    return {ra, rd};
  endfunction

  // R2 headphone volume with LRHPBOTH and LZCEN set
  function automatic logic [15:0] vol_word(input logic [6:0] v);
    return {7'h02, 2'b11, v};
  endfunction

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic             vol_mode_q, vol_mode_d;
  logic             pend_q, pend_d;
  logic [6:0]       vval_q, vval_d;
  logic             req_q, req_d;
  logic [15:0]      data_q, data_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rty_d      = rty_q;
    vol_mode_d = vol_mode_q;
    pend_d     = pend_q;
    vval_d     = vval_q;
    data_d     = data_q;
    ack_d      = 1'b0;
    done_d     = done_q;
    err_d      = err_q;

    // ack_q blocks the requester's still-high vol_req from re-capturing in the ack cycle
    if (vol_req && !pend_q && !ack_q && state_q != S_ERROR) begin
      pend_d = 1'b1;
      vval_d = vol_val;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PWRUP;
          cnt_d   = '0;
          idx_d   = '0;
          rty_d   = '0;
        end
      end
      S_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
          data_d  = table_word(idx_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (i2c_done) begin
          cnt_d = '0;
          if (!i2c_nack) begin
            rty_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = S_GAP;
            end
          end else if (rty_q == RTY_MAX) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            rty_d   = rty_q + 1'b1;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = vol_mode_q ? S_VOL_ISSUE : S_ISSUE;
          data_d  = vol_mode_q ? vol_word(vval_q) : table_word(idx_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d    = S_PWRUP;
          cnt_d      = '0;
          idx_d      = '0;
          rty_d      = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          vol_mode_d = 1'b0;
        end else if (pend_q) begin
          state_d    = S_VOL_ISSUE;
          vol_mode_d = 1'b1;
          data_d     = vol_word(vval_q);
        end
      end
      S_VOL_ISSUE: state_d = S_VOL_WAIT;
      S_VOL_WAIT: begin
        if (i2c_done) begin
          cnt_d = '0;
          if (!i2c_nack) begin
            rty_d      = '0;
            ack_d      = 1'b1;
            pend_d     = 1'b0;
            vol_mode_d = 1'b0;
            state_d    = S_DONE;
          end else if (rty_q == RTY_MAX) begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            done_d     = 1'b0;
            vol_mode_d = 1'b0;
          end else begin
            rty_d   = rty_q + 1'b1;
            state_d = S_GAP;
          end
        end
      end
      S_ERROR: begin
        if (start) begin
          state_d    = S_PWRUP;
          cnt_d      = '0;
          idx_d      = '0;
          rty_d      = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          vol_mode_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // request is a registered view of the next state so it rises on ISSUE entry
    req_d  = (state_d == S_ISSUE) || (state_d == S_WAIT) ||
             (state_d == S_VOL_ISSUE) || (state_d == S_VOL_WAIT);
    busy_d = req_d || (state_d == S_PWRUP) || (state_d == S_GAP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      rty_q      <= '0;
      vol_mode_q <= 1'b0;
      pend_q     <= 1'b0;
      vval_q     <= '0;
      req_q      <= 1'b0;
      data_q     <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rty_q      <= rty_d;
      vol_mode_q <= vol_mode_d;
      pend_q     <= pend_d;
      vval_q     <= vval_d;
      req_q      <= req_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign i2c_req      = req_q;
  assign i2c_dev_addr = DEV_ADDR;
  assign i2c_data     = data_q;
  assign vol_ack      = ack_q;
  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign cfg_error    = err_q;
  assign cfg_index    = idx_q;

endmodule

// File: doc/codec_config_sequencer.md
Name: codec_config_sequencer

Overview:
- Sequences WM8731 audio-codec configuration over a shared I2C write master.
- At start-up it waits for codec power-up, then walks a fixed 12-entry register table, one 16-bit word per I2C write.
- Retries NACKed writes and reports done or error.
- After init, it serves runtime headphone-volume writes from the game logic through a req/ack handshake.
- Sits between the top level and the I2C master inside the audio path.

Parameters:
DEV_ADDR, 7'h1A, codec 7-bit I2C device address.
PWRUP_CYCLES, 50000, clk cycles to wait after start before the first write (1 ms at 50 MHz).
GAP_CYCLES, 1000, idle cycles between consecutive writes and before a retry.
MAX_RETRY, 3, retries per word after the first attempt.

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins or restarts full configuration
i2c_req  out  1  write request to I2C master
i2c_dev_addr  out  7  device address, equal to DEV_ADDR
i2c_data  out  16  {reg_addr[6:0], reg_data[8:0]}
i2c_done  in  1  single-cycle pulse: current write finished
i2c_nack  in  1  valid with i2c_done; 1 = slave NACKed
vol_req  in  1  level; request a volume write
vol_val  in  7  headphone volume, sampled when vol_req is captured
vol_ack  out  1  single-cycle pulse when the volume write is ACKed
cfg_busy  out  1  sequence or volume write in progress
cfg_done  out  1  table fully written; sticky until start or reset
cfg_error  out  1  retries exhausted; sticky until start or reset
cfg_index  out  4  table index currently being written

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0: i2c_req, i2c_data, vol_ack, cfg_busy, cfg_done, cfg_error, cfg_index. i2c_dev_addr is always DEV_ADDR.
- Reset mid-transaction aborts immediately, with no completion. The pending volume request and the retry count are cleared.
- Table, index: reg, data:
  - 0: R15, 0x000
  - 1: R6, 0x010
  - 2: R0, 0x017
  - 3: R1, 0x017
  - 4: R2, 0x079
  - 5: R3, 0x079
  - 6: R4, 0x012
  - 7: R5, 0x000
  - 8: R7, 0x042
  - 9: R8, 0x000
  - 10: R9, 0x001
  - 11: R6, 0x000
- Volume word: {7'h02, 2'b11, vol_val_latched}, i.e. LRHPBOTH=1, LZCEN=1.
- States: IDLE, PWRUP, ISSUE, WAIT, GAP, DONE, ERROR, VOL_ISSUE, VOL_WAIT.
  - IDLE: on start -> PWRUP. cfg_busy=1, counter cleared, cfg_index=0.
  - PWRUP: counts PWRUP_CYCLES cycles -> ISSUE.
  - ISSUE: drive i2c_data from the table, assert i2c_req -> WAIT.
  - WAIT:
    - i2c_req held high with i2c_data stable until i2c_done.
    - i2c_req is low the cycle after i2c_done.
    - ACK: retry count cleared.
      - If index=11 -> DONE.
      - Otherwise index+1 and -> GAP.
    - NACK: retry+1 -> GAP, same index.
      - If retry was already MAX_RETRY -> ERROR instead.
  - GAP: counts GAP_CYCLES cycles -> ISSUE.
  - DONE: cfg_done=1, cfg_busy=0.
    - Pending volume request -> VOL_ISSUE, cfg_busy=1.
  - VOL_ISSUE / VOL_WAIT: same handshake and retry rules as ISSUE / WAIT.
    - A GAP_CYCLES gap precedes each retry.
    - ACK: vol_ack pulses 1 cycle, pending cleared, -> DONE.
    - Retries exhausted -> ERROR, cfg_done cleared.
  - ERROR: cfg_error=1, cfg_busy=0, cfg_index frozen at the failing entry. Only start or reset leaves it.
- Volume capture:
  - vol_req=1 while not pending: set pending and latch vol_val in that cycle, in any state except ERROR.
  - Only one request is pending at a time; further vol_req is ignored until vol_ack.
  - The requester holds vol_req until vol_ack. A new request re-captures on the cycle after vol_ack.
  - Pending requests raised during init are serviced only after DONE.
- start while cfg_busy=1: ignored.
- start in DONE or ERROR:
  - Clears cfg_done, cfg_error and the retry count, then restarts from PWRUP.
  - A pending volume request survives and is serviced after the new DONE.
- Simultaneous start and vol_req in DONE: start wins; the volume request is latched as pending.
- i2c_done outside WAIT/VOL_WAIT is ignored.
- Counters are sized to ceil(log2(max(PWRUP_CYCLES, GAP_CYCLES)+1)) bits.

Test Plan:
- Clean init (PWRUP_CYCLES=10, GAP_CYCLES=4, master model ACKs after 3 cycles), start pulse:
  - first i2c_req exactly 10 cycles after PWRUP entry, i2c_data=16'h1E00;
  - 12 writes in table order; the last is 16'h0C00;
  - cfg_done=1, cfg_busy=0, cfg_index=11.
- NACK recovery: NACK the first two attempts of index 2 -> three writes of 16'h0017, each separated by 4 idle cycles, then index 3 proceeds; cfg_error stays 0.
- Retry exhaustion: NACK every attempt at index 4 (MAX_RETRY=3) -> exactly 4 attempts of 16'h0479, then cfg_error=1, cfg_index=4, i2c_req=0; a later vol_req produces no write.
- Volume during init: vol_req with vol_val=7'h60 at index 5 -> no volume write until after index 11; then i2c_data=16'h05E0, then vol_ack pulses 1 cycle.
- Restart and collision:
  - start during init is ignored; write count stays 12.
  - start and vol_req(7'h7F) in the same DONE cycle -> full re-init, then 16'h05FF, then vol_ack.
- Reset mid-write: drive rst=0 while i2c_req=1 in WAIT -> all outputs 0 asynchronously, before the next clk edge; after release, no activity until start.
